mcl_sine_req_arbiter: RTL and testbench

//  Shares one sine pipeline (float in -> float out, avail/get handshake) among NUM_REQ requesters.

---
 rtl/mcl_sine_req_arbiter.sv | 148 ++++++++++++++
 tb/tb_mcl_sine_req_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcl_sine_req_arbiter.sv
// Shares one sine pipeline among NUM_REQ requesters.
// Operands are granted round-robin. A tag FIFO remembers which requester owns
// each operand inside the pipeline, so results are routed back in pipeline order.
// A flush controller stops new operands and reports when the pipeline is empty.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | normal operation, operands accepted
// ST_DRAIN | flush requested, no new operands, waiting for tag FIFO empty
// ST_DONE  | drain complete, flush_done pulses for this one cycle
// ST_HOLD  | drained, flush_req still high, idle until it drops
module mcl_sine_req_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int FLT_EXP      = 11,
  parameter int FLT_FRAC     = 52,
  parameter int MAX_INFLIGHT = 32,
  localparam int W           = FLT_EXP + FLT_FRAC + 1,
  localparam int IDX_W       = $clog2(NUM_REQ),
  localparam int CNT_W       = $clog2(MAX_INFLIGHT + 1),
  localparam int PTR_W       = $clog2(MAX_INFLIGHT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_avail,
  output logic [NUM_REQ-1:0]   req_get,
  input  logic [NUM_REQ*W-1:0] req_data,
  output logic                 pipe_avail_x,
  input  logic                 pipe_get_x,
  output logic [W-1:0]         pipe_data_x,
  input  logic                 pipe_res_avail,
  output logic                 pipe_res_get,
  input  logic [W-1:0]         pipe_res_data,
  output logic [NUM_REQ-1:0]   rsp_avail,
  input  logic [NUM_REQ-1:0]   rsp_get,
  output logic [W-1:0]         rsp_data,
  input  logic                 flush_req,
  output logic                 flush_done,
  output logic [CNT_W-1:0]     inflight_cnt,
  output logic                 err_orphan
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE, ST_HOLD} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant;
  logic              grant_vld;
  logic [IDX_W:0]    scan_sum;
  logic [IDX_W-1:0]  scan_idx;
  logic [IDX_W-1:0]  tag_mem [MAX_INFLIGHT];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  cnt;
  logic [IDX_W-1:0]  head_tag;
  logic              fifo_empty, fifo_full;
  logic              push, pop, orphan;
  logic [W-1:0]      req_word [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign req_word[i] = req_data[i*W +: W];
  end

  assign fifo_empty   = (cnt == '0);
  assign fifo_full    = (cnt == CNT_W'(MAX_INFLIGHT));
  assign head_tag     = tag_mem[rd_ptr];
  assign inflight_cnt = cnt;
  assign rsp_data     = pipe_res_data;
  assign pipe_data_x  = req_word[grant];

  // Round-robin scan: first requesting index at or above rr_ptr, wrapping.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan_sum >= (IDX_W+1)'(NUM_REQ))
        scan_sum = scan_sum - (IDX_W+1)'(NUM_REQ);
      scan_idx = scan_sum[IDX_W-1:0];
      if (!grant_vld && req_avail[scan_idx]) begin
        grant_vld = 1'b1;
        grant     = scan_idx;
      end
    end
  end

  // Handshake decode; all outputs are held quiet while reset is asserted.
  always_comb begin
    pipe_avail_x = !rst && (state == ST_RUN) && !fifo_full && grant_vld;
    push         = pipe_avail_x && pipe_get_x;
    req_get      = '0;
    if (push)
      req_get[grant] = 1'b1;
    rsp_avail = '0;
    if (!rst && !fifo_empty)
      rsp_avail[head_tag] = pipe_res_avail;
    pop          = !rst && !fifo_empty && pipe_res_avail && rsp_get[head_tag];
    orphan       = !rst && fifo_empty && pipe_res_avail;
    pipe_res_get = !rst && (fifo_empty ? pipe_res_avail : rsp_get[head_tag]);
    flush_done   = !rst && (state == ST_DONE);
  end

  // Flush controller next state.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (flush_req) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fifo_empty) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = flush_req ? ST_HOLD : ST_RUN;
      ST_HOLD:  if (!flush_req) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // Control registers: FSM, rr pointer, FIFO pointers, occupancy, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      err_orphan <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) begin
        rr_ptr <= (grant == IDX_W'(NUM_REQ-1)) ? '0 : grant + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (orphan)
        err_orphan <= 1'b1;
    end
  end

  // Tag storage; contents are don't-care while the occupancy says empty.
  always_ff @(posedge clk) begin
    if (push)
      tag_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_mcl_sine_req_arbiter.sv
// Directed bench for mcl_sine_req_arbiter (NUM_REQ=4, W=64, depth 32).
module tb_mcl_sine_req_arbiter;

  localparam int NR = 4;
  localparam int W  = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [NR-1:0] req_avail;
  logic [NR-1:0] req_get;
  logic [NR*W-1:0] req_data;
  logic          pipe_avail_x;
  logic          pipe_get_x;
  logic [W-1:0]  pipe_data_x;
  logic          pipe_res_avail;
  logic          pipe_res_get;
  logic [W-1:0]  pipe_res_data;
  logic [NR-1:0] rsp_avail;
  logic [NR-1:0] rsp_get;
  logic [W-1:0]  rsp_data;
  logic          flush_req;
  logic          flush_done;
  logic [5:0]    inflight_cnt;
  logic          err_orphan;
  logic [W-1:0]  rdw [NR];

  int n_cmp = 0;
  int n_err = 0;

  assign req_data = {rdw[3], rdw[2], rdw[1], rdw[0]};

  always #5 clk = ~clk;

  mcl_sine_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req_avail(req_avail), .req_get(req_get), .req_data(req_data),
    .pipe_avail_x(pipe_avail_x), .pipe_get_x(pipe_get_x), .pipe_data_x(pipe_data_x),
    .pipe_res_avail(pipe_res_avail), .pipe_res_get(pipe_res_get), .pipe_res_data(pipe_res_data),
    .rsp_avail(rsp_avail), .rsp_get(rsp_get), .rsp_data(rsp_data),
    .flush_req(flush_req), .flush_done(flush_done),
    .inflight_cnt(inflight_cnt), .err_orphan(err_orphan)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_avail = 4'hF; pipe_get_x = 1'b0; pipe_res_avail = 1'b0;
    pipe_res_data = '0; rsp_get = '0; flush_req = 1'b0;
    for (int i = 0; i < NR; i++) rdw[i] = 64'hA000_0000_0000_0000 | 64'(i);

    // T1 reset
    repeat (3) tick();
    #1;
    check("rst_pipe_avail", 64'(pipe_avail_x), 64'd0);
    check("rst_req_get", 64'(req_get), 64'd0);
    check("rst_rsp_avail", 64'(rsp_avail), 64'd0);
    check("rst_res_get", 64'(pipe_res_get), 64'd0);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    check("rst_cnt", 64'(inflight_cnt), 64'd0);
    check("rst_err", 64'(err_orphan), 64'd0);
    rst = 1'b0;
    #1;
    check("t1_pipe_avail", 64'(pipe_avail_x), 64'd1);
    check("t1_data_req0", pipe_data_x, 64'hA000_0000_0000_0000);

    // T2 round robin
    pipe_get_x = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("t2_grant", 64'(req_get), 64'(1 << (i % 4)));
      check("t2_data", pipe_data_x, 64'hA000_0000_0000_0000 | 64'(i % 4));
      tick();
    end
    pipe_get_x = 1'b0;
    #1;
    check("t2_cnt8", 64'(inflight_cnt), 64'd8);
    for (int i = 0; i < 8; i++) begin
      pipe_res_avail = 1'b1; rsp_get = 4'hF; pipe_res_data = 64'h5000 + 64'(i);
      #1;
      check("t2_ret_route", 64'(rsp_avail), 64'(1 << (i % 4)));
      check("t2_ret_data", rsp_data, 64'h5000 + 64'(i));
      tick();
    end
    pipe_res_avail = 1'b0; rsp_get = '0;
    #1;
    check("t2_cnt0", 64'(inflight_cnt), 64'd0);
    check("t2_no_orphan", 64'(err_orphan), 64'd0);

    // T3 routing
    rdw[2] = 64'h3FE0_0000_0000_0000;
    rdw[0] = 64'h3FF0_0000_0000_0000;
    req_avail = 4'b0100; pipe_get_x = 1'b1;
    #1;
    check("t3_grant2", 64'(req_get), 64'b0100);
    check("t3_data2", pipe_data_x, 64'h3FE0_0000_0000_0000);
    tick();
    req_avail = 4'b0001;
    #1;
    check("t3_grant0", 64'(req_get), 64'b0001);
    check("t3_data0", pipe_data_x, 64'h3FF0_0000_0000_0000);
    tick();
    req_avail = '0; pipe_get_x = 1'b0;
    pipe_res_avail = 1'b1; pipe_res_data = 64'h3FDE_AEE8_744B_05F0; rsp_get = 4'b0001;
    #1;
    check("t3_first_route", 64'(rsp_avail), 64'b0100);
    check("t3_early_get_ignored", 64'(pipe_res_get), 64'd0);
    tick();
    #1;
    check("t3_cnt_hold", 64'(inflight_cnt), 64'd2);
    rsp_get = 4'b0100;
    #1;
    check("t3_res_get", 64'(pipe_res_get), 64'd1);
    check("t3_rsp_data", rsp_data, 64'h3FDE_AEE8_744B_05F0);
    tick();
    pipe_res_data = 64'h3FEA_ED54_8F09_0CEE; rsp_get = 4'b0001;
    #1;
    check("t3_second_route", 64'(rsp_avail), 64'b0001);
    check("t3_res_get2", 64'(pipe_res_get), 64'd1);
    tick();
    pipe_res_avail = 1'b0; rsp_get = '0;
    #1;
    check("t3_cnt0", 64'(inflight_cnt), 64'd0);

    // T4 full / backpressure (rr pointer now at 1)
    req_avail = 4'hF; pipe_get_x = 1'b1;
    repeat (32) tick();
    #1;
    check("t4_cnt32", 64'(inflight_cnt), 64'd32);
    check("t4_full_avail", 64'(pipe_avail_x), 64'd0);
    check("t4_full_get", 64'(req_get), 64'd0);
    pipe_res_avail = 1'b1; rsp_get = 4'hF;
    #1;
    check("t4_head_route", 64'(rsp_avail), 64'b0010);
    check("t4_pop_get", 64'(pipe_res_get), 64'd1);
    check("t4_no_same_push", 64'(req_get), 64'd0);
    tick();
    pipe_res_avail = 1'b0;
    #1;
    check("t4_cnt31", 64'(inflight_cnt), 64'd31);
    check("t4_push_next", 64'(req_get), 64'b0010);
    tick();
    #1;
    check("t4_cnt32b", 64'(inflight_cnt), 64'd32);
    pipe_get_x = 1'b0; req_avail = '0;
    for (int k = 1; k <= 32; k++) begin
      pipe_res_avail = 1'b1; rsp_get = 4'hF;
      #1;
      check("t4_drain_route", 64'(rsp_avail), 64'(1 << ((1 + k) % 4)));
      tick();
    end
    pipe_res_avail = 1'b0; rsp_get = '0;
    #1;
    check("t4_cnt0", 64'(inflight_cnt), 64'd0);

    // T5 flush (rr pointer now at 2)
    req_avail = 4'hF; pipe_get_x = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t5_grant", 64'(req_get), 64'(1 << ((2 + i) % 4)));
      tick();
    end
    check("t5_cnt5", 64'(inflight_cnt), 64'd5);
    flush_req = 1'b1;
    #1;
    check("t5_same_cycle_xfer", 64'(req_get), 64'b1000);
    tick();
    #1;
    check("t5_cnt6", 64'(inflight_cnt), 64'd6);
    check("t5_drain_no_avail", 64'(pipe_avail_x), 64'd0);
    check("t5_drain_no_get", 64'(req_get), 64'd0);
    for (int k = 0; k < 6; k++) begin
      pipe_res_avail = 1'b1; rsp_get = 4'hF;
      #1;
      check("t5_ret_route", 64'(rsp_avail), 64'(1 << ((2 + k) % 4)));
      check("t5_no_done_yet", 64'(flush_done), 64'd0);
      tick();
    end
    pipe_res_avail = 1'b0; rsp_get = '0;
    #1;
    check("t5_cnt0", 64'(inflight_cnt), 64'd0);
    check("t5_done_not_yet", 64'(flush_done), 64'd0);
    tick();
    #1;
    check("t5_done_pulse", 64'(flush_done), 64'd1);
    tick();
    #1;
    check("t5_done_once", 64'(flush_done), 64'd0);
    check("t5_hold_no_avail", 64'(pipe_avail_x), 64'd0);
    tick();
    #1;
    check("t5_no_repulse", 64'(flush_done), 64'd0);
    flush_req = 1'b0;
    #1;
    check("t5_hold_exit_cycle", 64'(pipe_avail_x), 64'd0);
    tick();
    #1;
    check("t5_run_avail", 64'(pipe_avail_x), 64'd1);
    check("t5_run_grant", 64'(req_get), 64'b0001);
    pipe_get_x = 1'b0; req_avail = '0;

    // T6 orphan
    pipe_res_avail = 1'b1; pipe_res_data = 64'hDEAD;
    #1;
    check("t6_orphan_get", 64'(pipe_res_get), 64'd1);
    check("t6_orphan_rsp", 64'(rsp_avail), 64'd0);
    check("t6_err_before", 64'(err_orphan), 64'd0);
    tick();
    pipe_res_avail = 1'b0;
    #1;
    check("t6_err_set", 64'(err_orphan), 64'd1);
    repeat (3) tick();
    check("t6_err_sticky", 64'(err_orphan), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t6_err_clear", 64'(err_orphan), 64'd0);
    check("t6_cnt_clear", 64'(inflight_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
